// File: rtl/proj_sel_ctrl.sv
// Project-select controller: synchronise and debounce the select pins, then hand over between projects (drain, switch, wake).
// Latency: pin edge to DRAIN is SYNC_STAGES+STABLE_CYCLES cycles (+-1); DRAIN to RUN is 2*RESET_HOLD+1 cycles; all outputs registered.
// Backpressure: none; pin changes seen during a handover are not queued and are re-evaluated after RUN entry. Optional macro: SEL_LOCK_EN.
module proj_sel_ctrl #(
    parameter int SEL_BITS      = 3,
    parameter int NUM_DESIGNS   = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int RESET_HOLD    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SEL_BITS-1:0]    sel_raw,
    input  logic                   sel_lock,
    output logic [SEL_BITS-1:0]    sel,
    output logic [NUM_DESIGNS-1:0] proj_rst_n,
    output logic [NUM_DESIGNS-1:0] proj_clk_en,
    output logic                   busy
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [SEL_BITS:0] NUM_LIM   = (SEL_BITS + 1)'(NUM_DESIGNS);

`ifdef SEL_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_SWITCH,
        ST_WAKE
    } state_t;

    logic [SEL_BITS-1:0]    r_sync [SYNC_STAGES];
    logic [SEL_BITS-1:0]    r_cand;
    logic [CNT_W-1:0]       r_cnt;
    state_t                 r_state;
    logic [HOLD_W-1:0]      r_hold;
    logic [SEL_BITS-1:0]    r_tgt;
    logic [SEL_BITS-1:0]    r_sel;
    logic [NUM_DESIGNS-1:0] r_proj_rst_n;
    logic [NUM_DESIGNS-1:0] r_proj_clk_en;
    logic                   r_busy;

    logic [SEL_BITS-1:0]    w_sel_sync;
    logic                   w_lock;
    logic                   w_deb_en;
    logic                   w_cand_ok;
    logic                   w_accept;
    state_t                 w_state_nxt;
    logic [HOLD_W-1:0]      w_hold_nxt;
    logic [SEL_BITS-1:0]    w_tgt_nxt;
    logic [SEL_BITS-1:0]    w_sel_nxt;
    logic [NUM_DESIGNS-1:0] w_onehot;
    logic [NUM_DESIGNS-1:0] w_rst_nxt;
    logic [NUM_DESIGNS-1:0] w_en_nxt;
    logic                   w_busy_nxt;

    assign w_sel_sync = r_sync[SYNC_STAGES-1];
    assign w_lock     = LOCK_EN & sel_lock;

    // Debounce only counts while idle (INIT) or running unlocked; handover phases freeze it.
    assign w_deb_en  = (r_state == ST_INIT) || ((r_state == ST_RUN) && !w_lock);
    assign w_cand_ok = {1'b0, r_cand} < NUM_LIM;
    // In INIT a candidate equal to the reset value of sel is still adopted, so select 0 at power-up works.
    assign w_accept  = w_deb_en && (r_cnt == CNT_MAX) && w_cand_ok &&
                       ((r_cand != r_sel) || (r_state == ST_INIT));

    // Multi-flop synchroniser on the asynchronous select pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= sel_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Candidate tracking and stability counter; counter held at 0 outside the debounce window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else if (!w_deb_en) begin
            r_cand <= w_sel_sync;
            r_cnt  <= '0;
        end else if (w_sel_sync != r_cand) begin
            r_cand <= w_sel_sync;
            r_cnt  <= CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Handover FSM state, phase timer and latched target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_hold  <= '0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    // Next state plus next-cycle outputs, decoded from the next state so outputs line up with it.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = '0;
        w_tgt_nxt   = r_tgt;
        w_sel_nxt   = r_sel;
        w_onehot    = '0;
        w_rst_nxt   = '0;
        w_en_nxt    = '0;
        w_busy_nxt  = 1'b1;

        case (r_state)
            ST_INIT: begin
                if (w_accept) begin
                    w_tgt_nxt   = r_cand;
                    w_state_nxt = ST_SWITCH;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_tgt_nxt   = r_cand;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt = ST_SWITCH;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            ST_SWITCH: begin
                w_state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase

        // sel moves on the edge into SWITCH, while every project is gated and in reset.
        if (w_state_nxt == ST_SWITCH) begin
            w_sel_nxt = w_tgt_nxt;
        end
        w_onehot = NUM_DESIGNS'(1) << w_sel_nxt;

        case (w_state_nxt)
            ST_RUN: begin
                w_rst_nxt  = w_onehot;
                w_en_nxt   = w_onehot;
                w_busy_nxt = 1'b0;
            end
            ST_DRAIN, ST_WAKE: begin
                w_en_nxt = w_onehot;
            end
            default: begin
                w_rst_nxt = '0;
                w_en_nxt  = '0;
            end
        endcase
    end

    // Registered outputs to the downstream muxes and clock-gating cells.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel         <= '0;
            r_proj_rst_n  <= '0;
            r_proj_clk_en <= '0;
            r_busy        <= 1'b1;
        end else begin
            r_sel         <= w_sel_nxt;
            r_proj_rst_n  <= w_rst_nxt;
            r_proj_clk_en <= w_en_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign sel         = r_sel;
    assign proj_rst_n  = r_proj_rst_n;
    assign proj_clk_en = r_proj_clk_en;
    assign busy        = r_busy;

endmodule

// File: tb/tb_proj_sel_ctrl.sv
// Bench for proj_sel_ctrl with default parameters: table of directed vectors plus hand-written handover sequences.
// Latency: outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
// Backpressure: not applicable; every wait on the DUT is bounded by a cycle budget.
module tb_proj_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sel_raw;
    logic       sel_lock;
    logic [2:0] sel;
    logic [7:0] proj_rst_n;
    logic [7:0] proj_clk_en;
    logic       busy;

    int n_vec  = 0;
    int n_fail = 0;

    proj_sel_ctrl #(
        .SEL_BITS      (3),
        .NUM_DESIGNS   (8),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16),
        .RESET_HOLD    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_raw     (sel_raw),
        .sel_lock    (sel_lock),
        .sel         (sel),
        .proj_rst_n  (proj_rst_n),
        .proj_clk_en (proj_clk_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] raw;
        logic       lock;
        int         ticks;
        logic [2:0] e_sel;
        logic [7:0] e_rst;
        logic [7:0] e_en;
        logic       e_busy;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic check_outs(input string nm, input logic [2:0] e_sel, input logic [7:0] e_rst,
                              input logic [7:0] e_en, input logic e_busy);
        check({nm, ".sel"}, 32'(sel), 32'(e_sel));
        check({nm, ".proj_rst_n"}, 32'(proj_rst_n), 32'(e_rst));
        check({nm, ".proj_clk_en"}, 32'(proj_clk_en), 32'(e_en));
        check({nm, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    // One clock; at most one enable and one reset bit may ever be high.
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot_clk_en", 32'($countones(proj_clk_en) <= 1), 32'd1);
        check("onehot_rst_n", 32'($countones(proj_rst_n) <= 1), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, output int n);
        n = 0;
        while (busy !== lvl && n < budget) begin
            tick();
            n++;
        end
        check("wait_busy_timeout", 32'(busy), 32'(lvl));
    endtask

    task automatic wait_sel(input logic [2:0] v, input int budget, output int n);
        n = 0;
        while (sel !== v && n < budget) begin
            tick();
            n++;
        end
        check("wait_sel_timeout", 32'(sel), 32'(v));
    endtask

    function automatic void add(input logic [2:0] raw, input logic lock, input int ticks,
                                input logic [2:0] e_sel, input logic [7:0] e_rst,
                                input logic [7:0] e_en, input logic e_busy, input string name);
        vec_t v;
        v.raw = raw; v.lock = lock; v.ticks = ticks;
        v.e_sel = e_sel; v.e_rst = e_rst; v.e_en = e_en; v.e_busy = e_busy; v.name = name;
        tbl.push_back(v);
    endfunction

    initial begin
        int n;
        int first_busy;

        // Pin changed right after edge E0: E1 and E2 fill the synchroniser, E3 loads cand with cnt=1,
        // E18 reaches cnt=16, E19 leaves the state. Hence 19 ticks to SWITCH/DRAIN below.
        add(3'd3, 1'b0, 18, 3'd0, 8'h00, 8'h00, 1'b1, "init_wait");
        add(3'd3, 1'b0,  1, 3'd3, 8'h00, 8'h00, 1'b1, "init_switch");
        add(3'd3, 1'b0,  1, 3'd3, 8'h00, 8'h08, 1'b1, "wake3_first");
        add(3'd3, 1'b0,  7, 3'd3, 8'h00, 8'h08, 1'b1, "wake3_last");
        add(3'd3, 1'b0,  1, 3'd3, 8'h08, 8'h08, 1'b0, "run3");
        add(3'd5, 1'b0, 18, 3'd3, 8'h08, 8'h08, 1'b0, "run3_debounce");
        add(3'd5, 1'b0,  1, 3'd3, 8'h00, 8'h08, 1'b1, "drain3_first");
        add(3'd5, 1'b0,  7, 3'd3, 8'h00, 8'h08, 1'b1, "drain3_last");
        add(3'd5, 1'b0,  1, 3'd5, 8'h00, 8'h00, 1'b1, "switch_to5");
        add(3'd5, 1'b0,  1, 3'd5, 8'h00, 8'h20, 1'b1, "wake5_first");
        add(3'd5, 1'b0,  7, 3'd5, 8'h00, 8'h20, 1'b1, "wake5_last");
        add(3'd5, 1'b0,  1, 3'd5, 8'h20, 8'h20, 1'b0, "run5");
        add(3'd6, 1'b0, 10, 3'd5, 8'h20, 8'h20, 1'b0, "glitch6_pulse");
        add(3'd5, 1'b0, 30, 3'd5, 8'h20, 8'h20, 1'b0, "glitch6_settled");

        rst_n    = 1'b0;
        sel_raw  = 3'd3;
        sel_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 3'd0, 8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            sel_raw  = tbl[i].raw;
            sel_lock = tbl[i].lock;
            repeat (tbl[i].ticks) tick();
            check_outs(tbl[i].name, tbl[i].e_sel, tbl[i].e_rst, tbl[i].e_en, tbl[i].e_busy);
        end

        // Change request to 7, then pins move to 1 during WAKE of 7: not queued, re-debounced in RUN.
        sel_raw = 3'd7;
        wait_busy(1'b1, 40, n);
        check("drain7_latency", 32'(n), 32'd19);
        wait_sel(3'd7, 20, n);
        tick();
        tick();
        sel_raw = 3'd1;
        wait_busy(1'b0, 20, n);
        check_outs("run7", 3'd7, 8'h80, 8'h80, 1'b0);
        wait_busy(1'b1, 40, n);
        check("redebounce_window", 32'(n >= 16 && n <= 17), 32'd1);
        check_outs("drain7_to1", 3'd7, 8'h00, 8'h80, 1'b1);
        wait_busy(1'b0, 30, n);
        check_outs("run1", 3'd1, 8'h02, 8'h02, 1'b0);

        // Asynchronous reset in the middle of DRAIN, then re-selection of the pin value from INIT.
        sel_raw = 3'd2;
        wait_busy(1'b1, 40, n);
        tick();
        tick();
        tick();
        check_outs("drain1_mid", 3'd1, 8'h00, 8'h02, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 3'd0, 8'h00, 8'h00, 1'b1);
        tick();
        rst_n = 1'b1;
        wait_sel(3'd2, 40, n);
        check("reinit_latency", 32'(n), 32'd19);
        check_outs("reinit_switch", 3'd2, 8'h00, 8'h00, 1'b1);
        wait_busy(1'b0, 20, n);
        check("reinit_wake_len", 32'(n), 32'd9);
        check_outs("run2", 3'd2, 8'h04, 8'h04, 1'b0);

        // Lock held with a new pin value for 100 cycles.
        sel_lock   = 1'b1;
        sel_raw    = 3'd4;
        first_busy = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (busy === 1'b1 && first_busy < 0) first_busy = k;
        end
`ifdef SEL_LOCK_EN
        check("lock_no_switch", 32'(first_busy), 32'hffffffff);
        check_outs("locked_run2", 3'd2, 8'h04, 8'h04, 1'b0);
        sel_lock = 1'b0;
        wait_busy(1'b1, 40, n);
        check("unlock_window", 32'(n >= 16 && n <= 17), 32'd1);
`else
        check("lock_ignored_latency", 32'(first_busy), 32'd19);
        sel_lock = 1'b0;
`endif
        wait_busy(1'b0, 30, n);
        check_outs("run4", 3'd4, 8'h10, 8'h10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
